mac_feeder: RTL and testbench
=============================

// Module: mac_feeder
// PURPOSE
//  Initiator side of the MAC stream interface. Holds N-entry Q8.8 x and w vectors
//  loaded by a host write port. On go, drives one start-qualified burst of N beats
//  into a mac instance, then waits for its done and captures acc.
//  Returns the result, or a timeout error, on a valid/ready port.
// PARAMETERS
//  N        4   beats per dot product (>=2); address width AW = $clog2(N)
//  DW       16  data width, signed Q8.8
//  TIMEOUT  16  max WAIT cycles for mac_done before flagging an error (>=2)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous, active-low reset
//  wr_en      in   1   buffer write strobe
//  wr_sel     in   1   0 = x buffer, 1 = w buffer
//  wr_addr    in   AW  entry index 0..N-1
//  wr_data    in   DW  signed Q8.8 value
//  go         in   1   start request, sampled only in IDLE
//  busy       out  1   high whenever state != IDLE
//  mac_start  out  1   to mac.start, high with beat 0 only
//  mac_x      out  DW  to mac.x
//  mac_w      out  DW  to mac.w
//  mac_acc    in   DW  from mac.acc
//  mac_done   in   1   from mac.done
//  res_valid  out  1   result available
//  res_ready  in   1   consumer accepts result
//  res_data   out  DW  captured mac_acc (signed Q8.8), 0 on error
//  res_err    out  1   1 = timeout, qualified by res_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, both buffers cleared to 0, state IDLE,
//   idx/timer/armed = 0. Reset mid-operation aborts immediately; mac_start drops
//   the same instant. The paired mac must share this reset.
//  Registered outputs: every out port except busy is a flop; busy decodes state.
//  States: IDLE, FEED, WAIT, HOLD.
//  IDLE: wr_en=1 and go=0 -> buf[wr_sel][wr_addr] <= wr_data at the edge.
//   go=1 at edge E0 -> FEED, idx=0, mac_start=1, mac_x/mac_w = xbuf[0]/wbuf[0].
//   wr_en is dropped when go=1 in the same cycle, and whenever busy=1.
//  FEED: at edges E1..E(N-1), beat idx is driven (mac_x/w = buf[idx]), mac_start=0.
//   Beats are contiguous, one per cycle, with no stall.
//   At E_N: mac_x/w=0, go to WAIT, timer=0.
//  armed: set at any FEED/WAIT edge where mac_done is sampled 0, cleared on IDLE
//   exit. A done left high from a previous run is never accepted.
//  WAIT: on an edge with armed=1 and mac_done=1 -> res_data<=mac_acc, res_err=0,
//   res_valid=1, go to HOLD.
//   Otherwise timer++. If timer==TIMEOUT-1 -> res_data=0, res_err=1, res_valid=1,
//   go to HOLD. The error therefore appears at edge E_N+TIMEOUT.
//   mac_done seen in the same cycle as the timeout wins (success).
//  HOLD: res_valid, res_data and res_err stay stable until res_ready=1.
//   At the handshake edge: res_valid=0, res_err=0, go to IDLE.
//   res_data keeps its last value. go is ignored until back in IDLE.
//   res_ready outside HOLD has no effect.
//  Arithmetic: none. Data passes through bit-exact; the buffers are DW-bit signed.
//  Throughput: one op per N+1+D+1 cycles minimum, where D is the mac done latency.
// TESTING (bench instantiates mac_feeder + mac #(.N(4)); clk period 10 ns)
//  1 Load x=[0x0100,0x0200,0x0300,0x0400], w=4x0x0080, go.
//    -> mac_start high exactly 1 cycle with mac_x=0x0100, then 0x0200,0x0300,0x0400
//       on following cycles; res_valid with res_data=0x0500 (5.0), res_err=0.
//  2 x=[0x0100,0xFF00,0x0200,0xFE00], w=4x0x0100, go
//    -> res_data=0x0000, res_err=0; busy low one cycle after the handshake.
//  3 Hold res_ready=0 for 10 cycles after res_valid, pulse go and wr_en meanwhile
//    -> res_valid/res_data stable, busy=1, buffers unchanged; ready=1 -> IDLE next edge.
//  4 Replace mac with a stub holding mac_done=0
//    -> res_valid=1, res_err=1, res_data=0 exactly 16 edges after WAIT entry.
//  5 Stub mac_done held 1 for the whole op -> timeout error (armed never set).
//    Stub done 1 -> 0 -> 1 in WAIT -> result accepted on the second rising.
//  6 Deassert rst_n during beat 2
//    -> mac_start/mac_x/mac_w/res_valid = 0 with no clock edge; busy=0;
//       buffer readback after a new go drives 0s.

Source files
------------

// File: rtl/mac_feeder.sv
// -----------------------------------------------------------------------------
// mac_feeder
//   Initiator for a MAC stream. Two N-entry buffers (x and w, signed Q8.8) are
//   loaded through a host write port while the block is idle. A go request
//   sends one burst of N contiguous beats to the MAC, with mac_start marking
//   beat 0. The block then waits for mac_done and captures mac_acc. If done
//   does not arrive in time, it reports a timeout error instead. The result
//   stays on a valid/ready port until it is accepted.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en/sel/addr/data  buffer write (sel 0 = x, 1 = w), honoured only in IDLE
//   go                   start request, sampled only in IDLE
//   busy                 high whenever the FSM is not IDLE (decoded, not a flop)
//   mac_start/x/w        beat stream to the MAC (registered)
//   mac_acc/done         MAC result and completion flag
//   res_valid/ready      result handshake
//   res_data/err         captured accumulator (0 on error), timeout flag
//
// Handshake: a result is transferred on a rising edge where res_valid and
// res_ready are both 1. While res_valid is 1 and res_ready is 0, res_valid,
// res_data and res_err do not change.
// -----------------------------------------------------------------------------
module mac_feeder #(
  parameter int N       = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 16,
  localparam int AW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          go,
  output logic          busy,
  output logic          mac_start,
  output logic [DW-1:0] mac_x,
  output logic [DW-1:0] mac_w,
  input  logic [DW-1:0] mac_acc,
  input  logic          mac_done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FEED = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, nxt_idx;
  logic [TW-1:0] timer_q, timer_d;
  logic          armed_q, armed_d;
  logic [DW-1:0] xbuf_q [N];
  logic [DW-1:0] xbuf_d [N];
  logic [DW-1:0] wbuf_q [N];
  logic [DW-1:0] wbuf_d [N];
  logic          mac_start_q, mac_start_d;
  logic [DW-1:0] mac_x_q, mac_x_d;
  logic [DW-1:0] mac_w_q, mac_w_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_err_q, res_err_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    armed_d     = armed_q;
    xbuf_d      = xbuf_q;
    wbuf_d      = wbuf_q;
    mac_start_d = 1'b0;
    mac_x_d     = mac_x_q;
    mac_w_d     = mac_w_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    nxt_idx     = idx_q + AW'(1);

    case (state_q)
      S_IDLE: begin
        if (go) begin
          // go takes priority over a same-cycle write; beat 0 goes out now.
          state_d     = S_FEED;
          idx_d       = '0;
          armed_d     = 1'b0;
          mac_start_d = 1'b1;
          mac_x_d     = xbuf_q[0];
          mac_w_d     = wbuf_q[0];
        end else if (wr_en && (int'(wr_addr) < N)) begin
          if (wr_sel) wbuf_d[wr_addr] = wr_data;
          else        xbuf_d[wr_addr] = wr_data;
        end
      end

      S_FEED: begin
        // A done that is still high from an earlier run is ignored until
        // done has been seen low at least once during this run.
        if (!mac_done) armed_d = 1'b1;
        if (idx_q == AW'(N - 1)) begin
          mac_x_d = '0;
          mac_w_d = '0;
          timer_d = '0;
          state_d = S_WAIT;
        end else begin
          idx_d   = nxt_idx;
          mac_x_d = xbuf_q[nxt_idx];
          mac_w_d = wbuf_q[nxt_idx];
        end
      end

      S_WAIT: begin
        if (!mac_done) armed_d = 1'b1;
        // Done is checked first, so done on the final cycle still succeeds.
        if (armed_q && mac_done) begin
          res_data_d  = mac_acc;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_data_d  = '0;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_HOLD: begin
        if (res_ready) begin
          // res_data keeps its last value after the transfer.
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      armed_q     <= 1'b0;
      mac_start_q <= 1'b0;
      mac_x_q     <= '0;
      mac_w_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        xbuf_q[i] <= '0;
        wbuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      armed_q     <= armed_d;
      mac_start_q <= mac_start_d;
      mac_x_q     <= mac_x_d;
      mac_w_q     <= mac_w_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      for (int i = 0; i < N; i++) begin
        xbuf_q[i] <= xbuf_d[i];
        wbuf_q[i] <= wbuf_d[i];
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mac_start = mac_start_q;
  assign mac_x     = mac_x_q;
  assign mac_w     = mac_w_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_mac_feeder.sv
module tb_mac_feeder;

  localparam int N       = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 16;
  localparam int AW      = $clog2(N);

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en   = 1'b0;
  logic          wr_sel  = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          go      = 1'b0;
  logic          busy;
  logic          mac_start;
  logic [DW-1:0] mac_x, mac_w;
  logic [DW-1:0] mac_acc = '0;
  logic          mac_done;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_err;

  int checks   = 0;
  int failures = 0;

  mac_feeder #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .go        (go),
    .busy      (busy),
    .mac_start (mac_start),
    .mac_x     (mac_x),
    .mac_w     (mac_w),
    .mac_acc   (mac_acc),
    .mac_done  (mac_done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  // ---------------------------------------------------------------- MAC stub
  // mode 0: behaves like a mac (sums Q8.8 products, done level rises lat_cfg
  // cycles after the last beat, drops on the next start); 1: done stuck 0;
  // 2: done stuck 1; 3: done follows done_script.
  int                 mode        = 0;
  int                 lat_cfg     = 2;
  logic               done_script = 1'b0;
  logic               done_real   = 1'b0;
  logic signed [47:0] acc         = '0;
  int                 beat_cnt    = 0;
  int                 lat         = -1;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_real = 1'b0;
      acc       = '0;
      beat_cnt  = 0;
      lat       = -1;
      mac_acc   = '0;
    end else begin
      if (mac_start) begin
        acc       = $signed(mac_x) * $signed(mac_w);
        beat_cnt  = 1;
        done_real = 1'b0;
        lat       = -1;
      end else if (beat_cnt > 0 && beat_cnt < N) begin
        acc      = acc + $signed(mac_x) * $signed(mac_w);
        beat_cnt = beat_cnt + 1;
        if (beat_cnt == N) lat = lat_cfg;
      end else if (lat > 0) begin
        lat = lat - 1;
      end
      if (lat == 0) begin
        done_real = 1'b1;
        lat       = -1;
      end
      mac_acc = acc[23:8];
    end
  end

  assign mac_done = (mode == 0) ? done_real :
                    (mode == 2) ? 1'b1 :
                    (mode == 3) ? done_script : 1'b0;

  // ---------------------------------------------------------------- reference model
  // Timeline view: an op starts at edge E0; edges E1..E(N-1) carry beats,
  // E_N clears the data; afterwards each edge either accepts done (only once
  // done has been seen low since E0) or counts toward the deadline E_N+TIMEOUT.
  logic [DW-1:0] mx [N];
  logic [DW-1:0] mw [N];
  logic          m_busy  = 1'b0;
  logic          m_res   = 1'b0;
  logic          m_seen0 = 1'b0;
  int            k       = 0;
  logic [DW-1:0] m_dot   = '0;
  logic          e_start = 1'b0;
  logic [DW-1:0] e_x     = '0;
  logic [DW-1:0] e_w     = '0;
  logic          e_valid = 1'b0;
  logic [DW-1:0] e_data  = '0;
  logic          e_err   = 1'b0;

  function automatic logic [DW-1:0] dot_q88();
    longint s;
    s = 0;
    for (int i = 0; i < N; i++)
      s = s + longint'($signed(mx[i])) * longint'($signed(mw[i]));
    return s[23:8];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mx[i] = '0;
        mw[i] = '0;
      end
      m_busy = 1'b0; m_res = 1'b0; m_seen0 = 1'b0; k = 0;
      e_start = 1'b0; e_x = '0; e_w = '0;
      e_valid = 1'b0; e_data = '0; e_err = 1'b0;
    end else if (!m_busy) begin
      if (go) begin
        m_busy = 1'b1; k = 0; m_seen0 = 1'b0;
        m_dot = dot_q88();
        e_start = 1'b1; e_x = mx[0]; e_w = mw[0];
      end else if (wr_en) begin
        if (wr_sel) mw[wr_addr] = wr_data;
        else        mx[wr_addr] = wr_data;
      end
    end else if (!m_res) begin
      k = k + 1;
      e_start = 1'b0;
      if (k < N) begin
        e_x = mx[k]; e_w = mw[k];
      end else if (k == N) begin
        e_x = '0; e_w = '0;
      end else if (m_seen0 && mac_done) begin
        m_res = 1'b1; e_valid = 1'b1; e_data = m_dot; e_err = 1'b0;
      end else if (k - N == TIMEOUT) begin
        m_res = 1'b1; e_valid = 1'b1; e_data = '0; e_err = 1'b1;
      end
      if (!mac_done) m_seen0 = 1'b1;
    end else if (res_ready) begin
      m_busy = 1'b0; m_res = 1'b0; e_valid = 1'b0; e_err = 1'b0;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic sel, input int addr, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [N*DW-1:0] xv, input logic [N*DW-1:0] wv);
    for (int i = 0; i < N; i++) wr(1'b0, i, xv[DW*i +: DW]);
    for (int i = 0; i < N; i++) wr(1'b1, i, wv[DW*i +: DW]);
  endtask

  // Returns at the negedge after E0.
  task automatic go_pulse();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("result_arrives", res_valid, 1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("hs_busy_low", busy, 0);
    chk("hs_valid_low", res_valid, 0);
  endtask

  // ---------------------------------------------------------------- main
  int cyc, nw, guard, r;
  logic [N*DW-1:0] xv;

  initial begin
    // Cycle-by-cycle comparison against the model for the whole run.
    fork
      forever begin
        @(negedge clk);
        checks++;
        if ({busy, mac_start, mac_x, mac_w, res_valid, res_data, res_err} !==
            {m_busy, e_start, e_x, e_w, e_valid, e_data, e_err}) begin
          failures++;
          $display("FAIL cycle_model t=%0t actual busy=%b start=%b x=%h w=%h valid=%b data=%h err=%b required busy=%b start=%b x=%h w=%h valid=%b data=%h err=%b",
                   $time, busy, mac_start, mac_x, mac_w, res_valid, res_data, res_err,
                   m_busy, e_start, e_x, e_w, e_valid, e_data, e_err);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", mac_start, 0);
    chk("rst_x", mac_x, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    rst_n = 1'b1;

    // 1: 1,2,3,4 times 0.5 -> 5.0
    xv = 64'h0400_0300_0200_0100;
    load(xv, {4{16'h0080}});
    go_pulse();
    chk("t1_start_b0", mac_start, 1);
    chk("t1_x_b0", mac_x, 16'h0100);
    chk("t1_w_b0", mac_w, 16'h0080);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      chk("t1_start_bn", mac_start, 0);
      chk("t1_x_bn", mac_x, xv[DW*i +: DW]);
    end
    @(negedge clk);
    chk("t1_x_after", mac_x, 0);
    wait_valid(cyc);
    chk("t1_data", res_data, 16'h0500);
    chk("t1_err", res_err, 0);
    handshake();

    // 2: 1 - 1 + 2 - 2 -> 0
    load(64'hFE00_0200_FF00_0100, {4{16'h0100}});
    go_pulse();
    wait_valid(cyc);
    chk("t2_data", res_data, 16'h0000);
    chk("t2_err", res_err, 0);
    handshake();

    // 3: result held while consumer stalls; go/write ignored meanwhile
    load({4{16'h0100}}, {4{16'h0100}});
    go_pulse();
    wait_valid(cyc);
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid_held", res_valid, 1);
      chk("t3_data_held", res_data, 16'h0400);
      chk("t3_busy", busy, 1);
      go = (i == 3);
      wr_en = (i == 5); wr_sel = 1'b0; wr_addr = '0; wr_data = 16'h7777;
      @(negedge clk);
    end
    go = 1'b0; wr_en = 1'b0;
    handshake();
    go_pulse();
    chk("t3_buf_unchanged", mac_x, 16'h0100);
    wait_valid(cyc);
    chk("t3_data2", res_data, 16'h0400);
    handshake();

    // 4: done never rises -> error at E_N+TIMEOUT
    mode = 1;
    go_pulse();
    wait_valid(cyc);
    chk("t4_latency", cyc, N + TIMEOUT);
    chk("t4_err", res_err, 1);
    chk("t4_data", res_data, 0);
    handshake();

    // 5a: done stuck high -> never armed -> error
    mode = 2;
    go_pulse();
    wait_valid(cyc);
    chk("t5a_latency", cyc, N + TIMEOUT);
    chk("t5a_err", res_err, 1);
    handshake();

    // 5b: done 1 -> 0 -> 1 inside WAIT, sum 1+2+3+4 -> 10.0
    load(64'h0400_0300_0200_0100, {4{16'h0100}});
    mode = 3; done_script = 1'b1;
    go_pulse();
    repeat (N + 2) @(negedge clk);
    chk("t5b_not_early", res_valid, 0);
    done_script = 1'b0;
    repeat (2) @(negedge clk);
    done_script = 1'b1;
    wait_valid(cyc);
    chk("t5b_err", res_err, 0);
    chk("t5b_data", res_data, 16'h0A00);
    handshake();
    done_script = 1'b0;
    mode = 0;

    // 6: reset during beat 2
    load(64'h4444_3333_2222_1111, {4{16'h0100}});
    go_pulse();
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_start", mac_start, 0);
    chk("t6_x", mac_x, 0);
    chk("t6_w", mac_w, 0);
    chk("t6_valid", res_valid, 0);
    chk("t6_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go_pulse();
    chk("t6_buf_cleared_x", mac_x, 0);
    chk("t6_buf_cleared_w", mac_w, 0);
    wait_valid(cyc);
    chk("t6_data", res_data, 0);
    handshake();

    // Random ops with noise on go/wr/ready while busy.
    for (int op = 0; op < 25; op++) begin
      r = $urandom_range(0, 9);
      mode = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      lat_cfg = $urandom_range(0, 5);
      nw = $urandom_range(0, 6);
      for (int j = 0; j < nw; j++)
        wr(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), DW'($urandom));
      @(negedge clk);
      go = 1'b1;
      wr_en = 1'($urandom_range(0, 1));
      wr_sel = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, N - 1));
      wr_data = DW'($urandom);
      @(negedge clk);
      go = 1'b0; wr_en = 1'b0;
      guard = 0;
      while (m_busy && guard < 100) begin
        go = 1'($urandom_range(0, 1));
        wr_en = 1'($urandom_range(0, 1));
        wr_sel = 1'($urandom_range(0, 1));
        wr_addr = AW'($urandom_range(0, N - 1));
        wr_data = DW'($urandom);
        res_ready = ($urandom_range(0, 2) == 0);
        @(negedge clk);
        guard++;
      end
      go = 1'b0; wr_en = 1'b0; res_ready = 1'b0;
      chk("rand_op_done", busy, 0);
    end
    mode = 0;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
